// File: rtl/btn_request_capture_4ch.sv
// Four-channel button front end: synchronize, debounce and edge-detect raw
// button levels, then hold each press as a sticky request until acknowledged.
module btn_request_capture_4ch #(
    parameter int unsigned DB_CNT_MAX = 1000000,
    parameter int unsigned CNT_W      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_i,
    input  logic       ack_i,
    input  logic [1:0] ack_idx,
    output logic [3:0] pend_o,
    output logic [3:0] stable_o,
    output logic [3:0] press_o,
    output logic [3:0] drop_o
);

    localparam int unsigned N_CH = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_CH-1:0] s1;
    logic [N_CH-1:0] s2;
    logic [N_CH-1:0] stable_nxt;
    logic [N_CH-1:0] press_nxt;
    logic [N_CH-1:0] clr_c;
    logic [N_CH-1:0] pend_nxt;
    logic [N_CH-1:0] drop_nxt;

    // Two-flop synchronizer; only s2 is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_i;
            s2 <= s1;
        end
    end

    // Per-channel debounce: the level changes only after DB_CNT_MAX
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    for (genvar g = 0; g < N_CH; g++) begin : g_db
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             stable_ch_nxt;

        always_comb begin
            cnt_nxt       = '0;
            stable_ch_nxt = stable_o[g];
            if (s2[g] != stable_o[g]) begin
                if (cnt == CNT_LAST) begin
                    stable_ch_nxt = s2[g];
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else begin
                cnt <= cnt_nxt;
            end
        end

        assign stable_nxt[g] = stable_ch_nxt;
    end

    // Rising edge of the debounced level is a press; releases are silent.
    always_comb begin
        press_nxt = stable_nxt & ~stable_o;
    end

    // Acknowledge decode: one channel cleared per cycle while ack_i is high.
    always_comb begin
        clr_c = '0;
        if (ack_i) begin
            clr_c = N_CH'(4'b0001 << ack_idx);
        end
    end

    // Set wins over clear; a set on a bit already pending and not being
    // cleared is reported as a drop.
    always_comb begin
        pend_nxt = press_o | (pend_o & ~clr_c);
        drop_nxt = press_o & pend_o & ~clr_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_o <= '0;
            press_o  <= '0;
            pend_o   <= '0;
            drop_o   <= '0;
        end else begin
            stable_o <= stable_nxt;
            press_o  <= press_nxt;
            pend_o   <= pend_nxt;
            drop_o   <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_btn_request_capture_4ch.sv
// Scoreboard bench for btn_request_capture_4ch: a sliding-window reference
// model pushes expected outputs per edge, a monitor pops and compares.
module tb_btn_request_capture_4ch;

    localparam int unsigned DB = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned HL = DB + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_i;
    logic       ack_i;
    logic [1:0] ack_idx;
    logic [3:0] pend_o;
    logic [3:0] stable_o;
    logic [3:0] press_o;
    logic [3:0] drop_o;

    always #5 clk = ~clk;

    btn_request_capture_4ch #(
        .DB_CNT_MAX(DB),
        .CNT_W     (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_i),
        .ack_i   (ack_i),
        .ack_idx (ack_idx),
        .pend_o  (pend_o),
        .stable_o(stable_o),
        .press_o (press_o),
        .drop_o  (drop_o)
    );

    typedef struct packed {
        logic [3:0] stable;
        logic [3:0] press;
        logic [3:0] drop;
        logic [3:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: hist[j] is the btn level sampled j edges ago, so the
    // debouncer sees hist[2..DB+1]; a level flips when all of those disagree.
    logic [3:0] hist [HL];
    logic [3:0] m_stable = '0;
    logic [3:0] m_press  = '0;
    logic [3:0] m_pend   = '0;
    logic [3:0] m_drop   = '0;
    logic [3:0] m_clr;
    logic [3:0] m_nst;
    logic       m_all;

    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < HL; j++) hist[j] = '0;
            m_stable = '0;
            m_press  = '0;
            m_pend   = '0;
            m_drop   = '0;
        end else begin
            for (int j = HL - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = btn_i;
            m_clr = ack_i ? (4'b0001 << ack_idx) : 4'b0000;
            for (int c = 0; c < 4; c++) begin
                m_all = 1'b1;
                for (int j = 2; j < HL; j++) begin
                    if (hist[j][c] == m_stable[c]) m_all = 1'b0;
                end
                m_nst[c] = m_all ? ~m_stable[c] : m_stable[c];
            end
            m_drop   = m_press & m_pend & ~m_clr;
            m_pend   = m_press | (m_pend & ~m_clr);
            m_press  = m_nst & ~m_stable;
            m_stable = m_nst;
        end
        exp_q.push_back('{stable: m_stable, press: m_press, drop: m_drop, pend: m_pend});
    end

    // Monitor: every cycle the DUT presents a full output set to score.
    exp_t e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_stable", stable_o, e.stable);
            chk("sb_press",  press_o,  e.press);
            chk("sb_drop",   drop_o,   e.drop);
            chk("sb_pend",   pend_o,   e.pend);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_ack(input logic [1:0] idx);
        ack_i   = 1'b1;
        ack_idx = idx;
        step(1);
        ack_i   = 1'b0;
    endtask

    initial begin
        for (int j = 0; j < HL; j++) hist[j] = '0;
        rst     = 1'b1;
        btn_i   = '0;
        ack_i   = 1'b0;
        ack_idx = '0;
        step(2);
        chk("rst_pend", pend_o, 4'b0000);
        chk("rst_stable", stable_o, 4'b0000);
        chk("rst_press", press_o, 4'b0000);
        chk("rst_drop", drop_o, 4'b0000);
        rst = 1'b0;
        step(3);
        chk("idle_pend", pend_o, 4'b0000);
        chk("idle_stable", stable_o, 4'b0000);

        // Clean press on channel 2.
        btn_i = 4'b0100;
        step(6);
        chk("press_stable", stable_o, 4'b0100);
        chk("press_pulse", press_o, 4'b0100);
        step(1);
        chk("press_end", press_o, 4'b0000);
        chk("press_pend", pend_o, 4'b0100);

        // Three-cycle glitch on channel 1 is rejected.
        btn_i = 4'b0110;
        step(3);
        btn_i = 4'b0100;
        step(8);
        chk("glitch_stable", stable_o, 4'b0100);
        chk("glitch_pend", pend_o, 4'b0100);
        do_ack(2'd2);
        chk("ack2_pend", pend_o, 4'b0000);
        btn_i = 4'b0000;
        step(8);

        // Channels 0 and 3 together, then acks.
        btn_i = 4'b1001;
        step(7);
        chk("multi_pend", pend_o, 4'b1001);
        do_ack(2'd3);
        chk("ack3_pend", pend_o, 4'b0001);
        do_ack(2'd2);
        chk("ack_idle_pend", pend_o, 4'b0001);
        btn_i = 4'b0000;
        step(8);

        // Re-press channel 0 with the ack landing on the press cycle.
        btn_i = 4'b0001;
        step(6);
        chk("coinc_press", press_o, 4'b0001);
        do_ack(2'd0);
        chk("coinc_pend", pend_o, 4'b0001);
        chk("coinc_drop", drop_o, 4'b0000);
        btn_i = 4'b0000;
        step(8);
        btn_i = 4'b0001;
        step(7);
        chk("drop_pulse", drop_o, 4'b0001);
        chk("drop_pend", pend_o, 4'b0001);
        step(1);
        chk("drop_end", drop_o, 4'b0000);
        btn_i = 4'b0000;
        step(8);

        // Reset in the middle of a channel 1 debounce.
        btn_i = 4'b0010;
        step(3);
        rst = 1'b1;
        step(1);
        chk("mid_rst_pend", pend_o, 4'b0000);
        chk("mid_rst_stable", stable_o, 4'b0000);
        chk("mid_rst_press", press_o, 4'b0000);
        rst = 1'b0;
        step(6);
        chk("post_rst_press", press_o, 4'b0010);
        step(1);
        chk("post_rst_pend", pend_o, 4'b0010);
        do_ack(2'd1);

        // Randomized phase, scored entirely by the model.
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(5, 0) == 0) btn_i[c] = ~btn_i[c];
            end
            ack_i   = ($urandom_range(3, 0) == 0);
            ack_idx = 2'($urandom_range(3, 0));
            rst     = ($urandom_range(499, 0) == 0);
            step(1);
        end
        rst   = 1'b0;
        ack_i = 1'b0;
        btn_i = '0;
        step(12);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/btn_request_capture_4ch.md
# btn_request_capture_4ch

Four-channel button front end that feeds the 4-to-2 priority encoder. Raw asynchronous button levels are synchronized, debounced and edge-detected. Each press is held as a sticky pending request, and the pending vector drives the encoder's `D[3:0]` input. A request stays pending until the consumer acknowledges it by index, normally with the encoder's `Y` output qualified by `V`. The block targets the Basys 3 100 MHz clock.

## Interface
- `DB_CNT_MAX`, default 1000000: consecutive synchronized cycles an input must disagree with its debounced level before that level changes. The default is 10 ms at 100 MHz. Legal range is 2 to 2^`CNT_W`-1.
- `CNT_W`, default 20: width of each per-channel debounce counter.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_i`  in  4  raw asynchronous button levels; 1 means pressed.
- `ack_i`  in  1  one-cycle acknowledge strobe.
- `ack_idx`  in  2  channel index cleared when `ack_i`=1.
- `pend_o`  out  4  registered sticky pending requests; drives encoder `D`.
- `stable_o`  out  4  registered debounced button levels.
- `press_o`  out  4  one-cycle pulse per debounced 0->1 transition.
- `drop_o`  out  4  one-cycle pulse when a press arrives on a channel that is already pending and not being cleared.

## Operation
- **Synchronizer:** two flops per channel, `s1` then `s2`. Only `s2` is used downstream.
- **Debounce counter, per channel:**
  - If `s2`==`stable`, the counter resets to 0.
  - If `s2`!=`stable` and the counter is below `DB_CNT_MAX`-1, the counter increments.
  - If `s2`!=`stable` and the counter equals `DB_CNT_MAX`-1, then `stable` <= `s2` and the counter resets to 0.
  - Any return of `s2` to `stable` before then discards the count, so glitches are rejected.
- **Press detect:** `press_o[i]` is registered in the same edge that `stable[i]` goes 0->1. It is 1 for exactly one cycle. Release (1->0) produces no pulse.
- **Pending register, per channel `i`:**
  - Set: `press_o[i]` asserts in this cycle.
  - Clear: `ack_i`=1 and `ack_idx`==`i`.
  - Set and clear in the same cycle: set wins, so the bit stays 1 and the new press is retained.
  - Ack for a channel that is not pending: no effect.
  - Channels act independently. Several bits may be pending at once; the downstream encoder resolves priority.
- **Drop:**
  - `drop_o[i]` pulses for one cycle when a set event occurs while `pend_o[i]` is already 1 and is not being cleared in that cycle.
  - `pend_o[i]` stays 1.
  - No counting or queueing of repeat presses.
- **Reset:**
  - All of `s1`, `s2`, `stable_o`, the counters, `pend_o`, `press_o` and `drop_o` go to 0 at the first rising `clk` edge with `rst`=1.
  - Reset mid-debounce discards partial counts.
  - A button held through reset is treated as a new press: after release of `rst` it debounces 0->1 and generates `press_o` and a pending bit.

## Timing
- `btn_i` change to `s2` change: 2 edges.
- `s2` change to `stable_o` change: `DB_CNT_MAX` edges.
- Total latency: `DB_CNT_MAX`+2 cycles from the first edge sampling the new `btn_i` level.
- `press_o` asserts in the same cycle as `stable_o` rises. `pend_o` rises one cycle after `press_o`.
- Ack latency: `pend_o[ack_idx]` is 0 in the cycle after the `ack_i` edge.
- `ack_i` is sampled on every edge; holding it high for N cycles is N acks.
- No combinational path from any input to any output.

## Test plan
All scenarios use `DB_CNT_MAX`=4 and `CNT_W`=3.
- **Reset:** `rst`=1 for 2 cycles with `btn_i`=0000 -> all outputs 0000. Release -> outputs remain 0 with no activity.
- **Clean press:**
  - Stimulus: `btn_i[2]`=1 held.
  - `stable_o[2]` and `press_o[2]` = 1 exactly 6 cycles after the first sampling edge.
  - `press_o[2]` = 0 on the next cycle.
  - `pend_o`=0100 one cycle after `press_o`.
- **Glitch rejection:** `btn_i[1]` high for 3 cycles, then low -> `stable_o`, `press_o` and `pend_o` stay 0.
- **Multi-channel and ack:**
  - Stimulus: press channels 0 and 3 together.
  - `pend_o`=1001 after 7 cycles.
  - `ack_i`=1 with `ack_idx`=3 -> `pend_o`=0001 on the next cycle.
  - Ack with `ack_idx`=2 -> no change.
- **Simultaneous set and ack:**
  - Setup: channel 0 pending; release and re-press so that `press_o[0]` coincides with `ack_i`/`ack_idx`=0.
  - Response: `pend_o[0]` stays 1 and `drop_o[0]`=0.
  - Second press without an ack -> `drop_o[0]` pulses once and `pend_o[0]`=1.
- **Reset mid-operation:**
  - Stimulus: assert `rst` with `btn_i[1]` held high mid-count and `pend_o`=0001.
  - All outputs 0 after the reset edge.
  - After release, `press_o[1]` at cycle 6 and `pend_o`=0010 at cycle 7.
